// File: rtl/mem_wb_skid_pkg.sv
// mem_wb_skid_pkg: shared levels, reset constants and payload width; MEM_WB_HILO_EN adds the HI/LO channel.
package mem_wb_skid_pkg;
  localparam logic FLUSH = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam logic [DEF_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;
`ifdef MEM_WB_HILO_EN
  localparam bit HILO_EN = 1'b1;
`else
  localparam bit HILO_EN = 1'b0;
`endif
  function automatic int payload_w(input int data_w, input int addr_w);
    return 2 * (1 + addr_w + data_w) + (HILO_EN ? 1 + 2 * data_w : 0);
  endfunction
endpackage

// File: rtl/mem_wb_skid_slot.sv
// mem_wb_skid_slot: one valid bit plus packed payload with load, clear and async reset.
module mem_wb_skid_slot #(
  parameter int W = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  logic         valid_d, valid_q;
  logic [W-1:0] pl_d, pl_q;
  always_comb begin
    valid_d = clr ? 1'b0 : ld ? 1'b1 : valid_q;
    pl_d    = clr ? CLR_VAL : ld ? d : pl_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pl_q    <= CLR_VAL;
    end else begin
      valid_q <= valid_d;
      pl_q    <= pl_d;
    end
  end
  assign valid = valid_q;
  assign q     = pl_q;
endmodule

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM/WB valid/ready stage with 2-entry skid buffer; MEM_WB_HILO_EN adds the HI/LO channel.
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_w_reg,
  input  logic [ADDR_W-1:0] in_w_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_cp0_we,
  input  logic [ADDR_W-1:0] in_cp0_w_addr,
  input  logic [DATA_W-1:0] in_cp0_w_data,
`ifdef MEM_WB_HILO_EN
  input  logic              in_hilo_we,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  output logic              out_hilo_we,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_w_reg,
  output logic [ADDR_W-1:0] out_w_dest,
  output logic [DATA_W-1:0] out_data,
  output logic              out_cp0_we,
  output logic [ADDR_W-1:0] out_cp0_w_addr,
  output logic [DATA_W-1:0] out_cp0_w_data,
  output logic [1:0]        occupancy
);
  localparam int PL_W = payload_w(DATA_W, ADDR_W);
  localparam logic [PL_W-1:0] ZERO_PL = {
    WRITE_DISABLE, ADDR_W'(NOP_REG_ADDR), DATA_W'(ZERO_WORD),
    WRITE_DISABLE, ADDR_W'(NOP_REG_ADDR), DATA_W'(ZERO_WORD)
`ifdef MEM_WB_HILO_EN
    , WRITE_DISABLE, DATA_W'(ZERO_WORD), DATA_W'(ZERO_WORD)
`endif
  };
  logic [PL_W-1:0] in_pl, m_pl, s_pl, m_d;
  logic m_valid, s_valid, m_ld, m_clr, s_ld, s_clr;
  logic accept, drain, do_flush, m_w_reg, m_cp0_we;
  assign in_pl = {
    in_w_reg, in_w_dest, in_data, in_cp0_we, in_cp0_w_addr, in_cp0_w_data
`ifdef MEM_WB_HILO_EN
    , in_hilo_we, in_hi, in_lo
`endif
  };
  // in_ready comes straight from the S flop, so MEM never sees a combinational path from WB
  assign in_ready = !s_valid;
  always_comb begin
    accept   = in_valid & in_ready;
    drain    = m_valid & out_ready;
    do_flush = flush == FLUSH;
    m_ld     = (!m_valid & accept) | (drain & (s_valid | accept));
    m_clr    = do_flush | (drain & !s_valid & !accept);
    m_d      = s_valid ? s_pl : in_pl;
    s_ld     = m_valid & !drain & accept;
    s_clr    = do_flush | (drain & s_valid);
  end
  mem_wb_skid_slot #(.W(PL_W), .CLR_VAL(ZERO_PL)) u_m (
    .clk(clk), .rst_n(rst_n), .clr(m_clr), .ld(m_ld), .d(m_d), .valid(m_valid), .q(m_pl)
  );
  mem_wb_skid_slot #(.W(PL_W), .CLR_VAL(ZERO_PL)) u_s (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .ld(s_ld), .d(in_pl), .valid(s_valid), .q(s_pl)
  );
`ifdef MEM_WB_HILO_EN
  logic m_hilo_we;
  assign {m_w_reg, out_w_dest, out_data, m_cp0_we, out_cp0_w_addr, out_cp0_w_data,
          m_hilo_we, out_hi, out_lo} = m_pl;
  assign out_hilo_we = m_valid ? m_hilo_we : WRITE_DISABLE;
`else
  assign {m_w_reg, out_w_dest, out_data, m_cp0_we, out_cp0_w_addr, out_cp0_w_data} = m_pl;
`endif
  assign out_valid  = m_valid;
  assign out_w_reg  = m_valid ? m_w_reg : WRITE_DISABLE;
  assign out_cp0_we = m_valid ? m_cp0_we : WRITE_DISABLE;
  assign occupancy  = {1'b0, m_valid} + {1'b0, s_valid};
endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: scoreboard bench for mem_wb_skid; HI/LO checks build with MEM_WB_HILO_EN.
module tb_mem_wb_skid;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_w_reg = 1'b0, in_cp0_we = 1'b0, in_hilo_we = 1'b0;
  logic [4:0] in_w_dest = '0, in_cp0_w_addr = '0;
  logic [31:0] in_data = '0, in_cp0_w_data = '0, in_hi = '0, in_lo = '0;
  logic in_ready, out_valid, out_w_reg, out_cp0_we;
  logic [4:0] out_w_dest, out_cp0_w_addr;
  logic [31:0] out_data, out_cp0_w_data;
  logic [1:0] occupancy;
`ifdef MEM_WB_HILO_EN
  logic out_hilo_we;
  logic [31:0] out_hi, out_lo;
`endif
  typedef struct packed {
    logic w; logic [4:0] d; logic [31:0] x;
    logic c; logic [4:0] a; logic [31:0] cd;
    logic h; logic [31:0] hi; logic [31:0] lo;
  } beat_t;
  beat_t sb[$];
  beat_t mon_a, mon_e;
  int n_cmp = 0, n_err = 0;

  mem_wb_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_w_reg(in_w_reg), .in_w_dest(in_w_dest), .in_data(in_data),
    .in_cp0_we(in_cp0_we), .in_cp0_w_addr(in_cp0_w_addr), .in_cp0_w_data(in_cp0_w_data),
`ifdef MEM_WB_HILO_EN
    .in_hilo_we(in_hilo_we), .in_hi(in_hi), .in_lo(in_lo),
    .out_hilo_we(out_hilo_we), .out_hi(out_hi), .out_lo(out_lo),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_w_reg(out_w_reg),
    .out_w_dest(out_w_dest), .out_data(out_data), .out_cp0_we(out_cp0_we),
    .out_cp0_w_addr(out_cp0_w_addr), .out_cp0_w_data(out_cp0_w_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic w, input logic [4:0] d, input logic [31:0] x,
                               input logic c, input logic [4:0] a, input logic [31:0] cd,
                               input logic h, input logic [31:0] hi, input logic [31:0] lo);
    beat_t b;
    b = {w, d, x, c, a, cd, h, hi, lo};
`ifndef MEM_WB_HILO_EN
    b.h = 1'b0; b.hi = '0; b.lo = '0;
`endif
    return b;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input beat_t b);
    {in_w_reg, in_w_dest, in_data, in_cp0_we, in_cp0_w_addr, in_cp0_w_data,
     in_hilo_we, in_hi, in_lo} = b;
  endtask

  task automatic send(input beat_t b);
    drive(b);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        sb.push_back(b);
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got in_ready=0 for 20 cycles expected 1");
  endtask

  // beats leave on the edge after out_valid & out_ready is seen here
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
`ifdef MEM_WB_HILO_EN
      mon_a = {out_w_reg, out_w_dest, out_data, out_cp0_we, out_cp0_w_addr, out_cp0_w_data,
               out_hilo_we, out_hi, out_lo};
`else
      mon_a = {out_w_reg, out_w_dest, out_data, out_cp0_we, out_cp0_w_addr, out_cp0_w_data,
               1'b0, 32'h0, 32'h0};
`endif
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got %h expected none", mon_a);
      end else begin
        mon_e = sb.pop_front();
        if (mon_a !== mon_e) begin
          n_err++;
          $display("FAIL beat: got %h expected %h", mon_a, mon_e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(mk(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
      chk("stream_in_ready", in_ready, 1);
      if (i == 1) chk("stream_latency", out_valid, 1);
    end
    repeat (3) tick();
    chk("stream_sb_empty", sb.size(), 0);
    chk("stream_occ", occupancy, 0);
    out_ready = 1'b0;
    send(mk(1'b1, 5'd3, 32'hAAAA0001, 1'b1, 5'd12, 32'h55, 1'b0, 32'h0, 32'h0));
    send(mk(1'b0, 5'd4, 32'hBBBB0002, 1'b0, 5'd13, 32'h66, 1'b0, 32'h0, 32'h0));
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_data", out_data, 32'hAAAA0001);
    tick();
    chk("bp_hold", out_data, 32'hAAAA0001);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_occ_drained", occupancy, 0);
    out_ready = 1'b0;
    send(mk(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
    chk("fl_occ_before", occupancy, 1);
    drive(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234, 1'b0, 32'h0, 32'h0));
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_cp0_we", out_cp0_we, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_in_ready", in_ready, 1);
    send(mk(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
    chk("gate_w_reg_on", out_w_reg, 1);
    out_ready = 1'b1;
    tick();
    chk("gate_out_valid", out_valid, 0);
    chk("gate_w_reg_off", out_w_reg, 0);
    chk("gate_sb_empty", sb.size(), 0);
`ifdef MEM_WB_HILO_EN
    out_ready = 1'b0;
    send(mk(1'b0, 5'd1, 32'hF00D, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0));
    send(mk(1'b0, 5'd2, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h12345678, 32'h9ABCDEF0));
    chk("hilo_occ", occupancy, 2);
    chk("hilo_gate_off", out_hilo_we, 0);
    out_ready = 1'b1;
    tick();
    chk("hilo_hi", out_hi, 32'h12345678);
    chk("hilo_lo", out_lo, 32'h9ABCDEF0);
    chk("hilo_we", out_hilo_we, 1);
    repeat (2) tick();
    chk("hilo_sb_empty", sb.size(), 0);
`endif
    out_ready = 1'b0;
    send(mk(1'b1, 5'd5, 32'hC0DE0001, 1'b1, 5'd2, 32'h11, 1'b0, 32'h0, 32'h0));
    send(mk(1'b1, 5'd6, 32'hC0DE0002, 1'b1, 5'd3, 32'h22, 1'b0, 32'h0, 32'h0));
    chk("mrst_occ_before", occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_w_reg", out_w_reg, 0);
    chk("mrst_out_data", out_data, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_after", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
